// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions used by the hazard controller.
//
// Contents:
//   PC_SEL_*       PC mux select encodings driven by the EX-stage branch/jump logic
//   OPCODE_BRANCH  conditional-branch major opcode
//   hazard_state_t hazard controller FSM states
//   load_use_hit   source/destination match helper for load-use detection
package hazard_ctrl_pkg;

    localparam logic [2:0] PC_SEL_SEQ    = 3'b000;
    localparam logic [2:0] PC_SEL_JAL    = 3'b001;
    localparam logic [2:0] PC_SEL_BRANCH = 3'b010;
    localparam logic [2:0] PC_SEL_JALR   = 3'b011;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } hazard_state_t;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    function automatic logic load_use_hit(
        input logic [4:0] rs1_addr,
        input logic       uses_rs1,
        input logic [4:0] rs2_addr,
        input logic       uses_rs2,
        input logic [4:0] rd_addr
    );
        logic hit;
        hit = (rd_addr != 5'd0) &&
              ((uses_rs1 && (rs1_addr == rd_addr)) ||
               (uses_rs2 && (rs2_addr == rd_addr)));
        return hit;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
//
// Ports:
//   clk      clock, rising edge
//   clear_n  synchronous active-low clear
//   inc      count enable, one increment per cycle
//   count    current value, holds at all-ones instead of wrapping
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump redirects,
// data-memory wait freezes and a sticky memory-timeout fault.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   id_rs1_addr/id_rs2_addr         ID source registers, id_uses_rs1/rs2 qualify them
//   ex_valid, ex_rd_addr            EX instruction valid and its destination
//   ex_mem_read                     EX instruction is a load
//   ex_pc_source                    EX branch/jump PC source, 000 = sequential
//   dmem_req, dmem_ack              MEM-stage data-memory handshake
//   pc_write, if_id_write           PC and IF/ID load enables
//   pipe_hold                       freezes ID/EX, EX/MEM and MEM/WB
//   if_id_flush, id_ex_flush        bubble insertion
//   pc_sel                          PC mux select
//   fault                           sticky memory-timeout flag
//   stall_cnt, flush_cnt            saturating performance counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_mem_read,
    input  logic [2:0]  ex_pc_source,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        pipe_hold,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [2:0]  pc_sel,
    output logic        fault,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int WAIT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    // The counter holds the number of frozen cycles already seen, so the fault
    // is raised at the end of the frozen cycle that brings it to WAIT_TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (WAIT_TIMEOUT < 1) ? '0 : WAIT_W'(WAIT_TIMEOUT - 1);

    hazard_state_t     state;
    logic [WAIT_W-1:0] wait_cnt;

    logic freeze;
    logic redirect_req;
    logic load_use;
    logic in_fault;
    logic stall_inc;
    logic flush_inc;

    always_comb begin
        freeze       = dmem_req && !dmem_ack;
        redirect_req = ex_valid && (ex_pc_source != PC_SEL_SEQ);
        load_use     = ex_valid && ex_mem_read &&
                       load_use_hit(id_rs1_addr, id_uses_rs1,
                                    id_rs2_addr, id_uses_rs2, ex_rd_addr);
        in_fault     = (state == ST_FAULT);
        // Only the hazard that actually wins arbitration is counted; a redirect
        // hidden behind a freeze is taken later, once EX is released.
        stall_inc    = !in_fault && (freeze || (load_use && !redirect_req));
        flush_inc    = !in_fault && !freeze && redirect_req;
    end

    // Memory-wait watchdog. FAULT is absorbing; only reset leaves it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (freeze) begin
                        wait_cnt <= WAIT_W'(1);
                        state    <= (WAIT_TIMEOUT <= 1) ? ST_FAULT : ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!freeze) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt >= WAIT_LAST) begin
                            state <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign fault = in_fault;

    // Control decode, strictly prioritised: reset, fault, freeze, redirect,
    // load-use, then the free-running default.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        pipe_hold   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_sel      = PC_SEL_SEQ;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (in_fault || freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (redirect_req) begin
            pc_sel      = ex_pc_source;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk     (clk),
        .clear_n (rst_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk     (clk),
        .clear_n (rst_n),
        .inc     (flush_inc),
        .count   (flush_cnt)
    );

endmodule
